// File: rtl/iomem_wb_bridge.sv
// iomem_wb_bridge: picosoc iomem to multi-slave Wishbone classic bridge.
// Decodes the request address to a one-hot slave select (lowest index wins),
// muxes the selected slave's read data back, and answers unmapped addresses
// and stalled slaves with ERR_DATA so that the CPU never hangs.
module iomem_wb_bridge #(
    parameter int                        NUM_SLAVES     = 2,
    parameter logic [7:0]                WINDOW_MIN     = 8'h03,
    parameter logic [32*NUM_SLAVES-1:0]  SLAVE_BASE     = {32'h0310_0000, 32'h0300_0000},
    parameter logic [32*NUM_SLAVES-1:0]  SLAVE_MASK     = {32'hFFF0_0000, 32'hFFF0_0000},
    parameter int                        TIMEOUT_CYCLES = 255,
    parameter logic [31:0]               ERR_DATA       = 32'hBADB_AD00
) (
    input  logic                         clk,
    input  logic                         resetn,
    input  logic                         iomem_valid,
    output logic                         iomem_ready,
    input  logic [3:0]                   iomem_wstrb,
    input  logic [31:0]                  iomem_addr,
    input  logic [31:0]                  iomem_wdata,
    output logic [31:0]                  iomem_rdata,
    output logic [31:0]                  wbm_adr_o,
    output logic [31:0]                  wbm_dat_o,
    output logic                         wbm_we_o,
    output logic [3:0]                   wbm_sel_o,
    output logic [NUM_SLAVES-1:0]        wbm_cyc_o,
    output logic [NUM_SLAVES-1:0]        wbm_stb_o,
    input  logic [NUM_SLAVES-1:0]        wbm_ack_i,
    input  logic [32*NUM_SLAVES-1:0]     wbm_dat_i,
    output logic                         bus_timeout,
    output logic [7:0]                   err_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Last counter value before the strobe has been held TIMEOUT_CYCLES cycles.
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t                 state_reg;
    logic [15:0]            tmo_count_reg;
    logic [NUM_SLAVES-1:0]  hit;
    logic [NUM_SLAVES-1:0]  dec_onehot;
    logic [31:0]            rd_slice [NUM_SLAVES];
    logic [31:0]            rd_mux;
    logic                   ack_sel;
    logic                   in_window;
    logic [7:0]             err_count_next;

    // Per-slave address match and read-data gating by the active select.
    generate
        for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_slave
            assign hit[gi] = ((iomem_addr & SLAVE_MASK[32*gi +: 32]) ==
                              (SLAVE_BASE[32*gi +: 32] & SLAVE_MASK[32*gi +: 32]));
            assign rd_slice[gi] = wbm_cyc_o[gi] ? wbm_dat_i[32*gi +: 32] : 32'h0;
        end
    endgenerate

    // Priority decode: scanning downward leaves the lowest matching index.
    always_comb begin
        dec_onehot = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (hit[i]) begin
                dec_onehot    = '0;
                dec_onehot[i] = 1'b1;
            end
        end
    end

    // Read mux over the one-hot select; only the selected slave's data survives.
    always_comb begin
        rd_mux = 32'h0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            rd_mux = rd_mux | rd_slice[i];
        end
    end

    // Acks from unselected slaves are masked out by the one-hot cycle.
    assign ack_sel        = |(wbm_ack_i & wbm_cyc_o);
    assign in_window      = (iomem_addr[31:24] >= WINDOW_MIN);
    assign err_count_next = (err_count == 8'hFF) ? err_count : err_count + 8'd1;
    assign wbm_stb_o      = wbm_cyc_o;

    // Bridge FSM with all outputs registered.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg     <= IDLE;
            tmo_count_reg <= 16'h0;
            iomem_ready   <= 1'b0;
            iomem_rdata   <= 32'h0;
            wbm_adr_o     <= 32'h0;
            wbm_dat_o     <= 32'h0;
            wbm_we_o      <= 1'b0;
            wbm_sel_o     <= 4'h0;
            wbm_cyc_o     <= '0;
            bus_timeout   <= 1'b0;
            err_count     <= 8'h0;
        end else begin
            iomem_ready <= 1'b0;
            bus_timeout <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (iomem_valid && in_window) begin
                        wbm_adr_o <= iomem_addr;
                        wbm_dat_o <= iomem_wdata;
                        wbm_sel_o <= (|iomem_wstrb) ? iomem_wstrb : 4'hF;
                        if (|hit) begin
                            wbm_we_o      <= |iomem_wstrb;
                            wbm_cyc_o     <= dec_onehot;
                            tmo_count_reg <= 16'h0;
                            state_reg     <= BUS;
                        end else begin
                            // Unmapped: no Wishbone cycle, so write enable stays low.
                            wbm_we_o    <= 1'b0;
                            iomem_rdata <= ERR_DATA;
                            iomem_ready <= 1'b1;
                            err_count   <= err_count_next;
                            state_reg   <= DONE;
                        end
                    end
                end
                BUS: begin
                    if (ack_sel) begin
                        iomem_rdata <= rd_mux;
                        iomem_ready <= 1'b1;
                        wbm_cyc_o   <= '0;
                        wbm_we_o    <= 1'b0;
                        state_reg   <= DONE;
                    end else if (tmo_count_reg == TMO_LAST) begin
                        iomem_rdata <= ERR_DATA;
                        iomem_ready <= 1'b1;
                        bus_timeout <= 1'b1;
                        wbm_cyc_o   <= '0;
                        wbm_we_o    <= 1'b0;
                        err_count   <= err_count_next;
                        state_reg   <= DONE;
                    end else begin
                        tmo_count_reg <= tmo_count_reg + 16'd1;
                    end
                end
                DONE: begin
                    // One dead cycle lets picosoc drop valid before the next decode.
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_iomem_wb_bridge.sv
// Testbench for iomem_wb_bridge: constant vector table, randomized traffic
// against a transaction-level reference model, and hand-written reset sequences.
module tb_iomem_wb_bridge;

    localparam int          NS  = 2;
    localparam int          TO  = 4;
    localparam logic [31:0] ERR = 32'hBADB_AD00;
    localparam int          MAXC = 12;

    logic              clk = 1'b0;
    logic              resetn;
    logic              iomem_valid;
    logic              iomem_ready;
    logic [3:0]        iomem_wstrb;
    logic [31:0]       iomem_addr;
    logic [31:0]       iomem_wdata;
    logic [31:0]       iomem_rdata;
    logic [31:0]       wbm_adr_o;
    logic [31:0]       wbm_dat_o;
    logic              wbm_we_o;
    logic [3:0]        wbm_sel_o;
    logic [NS-1:0]     wbm_cyc_o;
    logic [NS-1:0]     wbm_stb_o;
    logic [NS-1:0]     wbm_ack_i;
    logic [32*NS-1:0]  wbm_dat_i;
    logic              bus_timeout;
    logic [7:0]        err_count;

    always #5 clk = ~clk;

    // Slave 1 gets a wide mask so 0x0300_xxxx matches both slaves and
    // priority decode is exercised.
    iomem_wb_bridge #(
        .NUM_SLAVES     (NS),
        .WINDOW_MIN     (8'h03),
        .SLAVE_BASE     ({32'h0310_0000, 32'h0300_0000}),
        .SLAVE_MASK     ({32'hFF00_0000, 32'hFFF0_0000}),
        .TIMEOUT_CYCLES (TO),
        .ERR_DATA       (ERR)
    ) dut (
        .clk         (clk),
        .resetn      (resetn),
        .iomem_valid (iomem_valid),
        .iomem_ready (iomem_ready),
        .iomem_wstrb (iomem_wstrb),
        .iomem_addr  (iomem_addr),
        .iomem_wdata (iomem_wdata),
        .iomem_rdata (iomem_rdata),
        .wbm_adr_o   (wbm_adr_o),
        .wbm_dat_o   (wbm_dat_o),
        .wbm_we_o    (wbm_we_o),
        .wbm_sel_o   (wbm_sel_o),
        .wbm_cyc_o   (wbm_cyc_o),
        .wbm_stb_o   (wbm_stb_o),
        .wbm_ack_i   (wbm_ack_i),
        .wbm_dat_i   (wbm_dat_i),
        .bus_timeout (bus_timeout),
        .err_count   (err_count)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          txn_no   = 0;
    logic [7:0]  err_model;
    logic [31:0] sdata  [NS];
    logic [31:0] base_a [NS];
    logic [31:0] mask_a [NS];

    always_comb begin
        wbm_dat_i = '0;
        for (int s = 0; s < NS; s++) wbm_dat_i[32*s +: 32] = sdata[s];
    end

    typedef struct {
        int            ready;
        logic [31:0]   rdata;
        bit            to;
        logic [NS-1:0] cyc;
        int            cycles;
        logic [7:0]    err;
    } exp_t;

    typedef struct {
        int            ready_cycle;
        logic [31:0]   rdata;
        int            to_pulses;
        bit            to_at_ready;
        logic [NS-1:0] cyc;
        int            cyc_cycles;
        int            stb_bad;
        logic [31:0]   adr;
        logic [31:0]   dat;
        logic [3:0]    sel;
        logic          we;
        logic          ready_after;
        logic          cyc_after;
        logic          to_after;
        logic [7:0]    err;
    } obs_t;

    typedef struct {
        logic [31:0]   addr;
        logic [3:0]    wstrb;
        logic [31:0]   wdata;
        int            ack_after;
        bit            spur;
        int            ready;
        logic [31:0]   rdata;
        bit            to;
        logic [NS-1:0] cyc;
        int            cycles;
        logic [7:0]    err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h", name, act, req);
        end
    endtask

    // Reference decode: lowest slave whose masked base matches.
    function automatic int decode(input logic [31:0] addr);
        for (int i = 0; i < NS; i++)
            if ((addr & mask_a[i]) == (base_a[i] & mask_a[i])) return i;
        return -1;
    endfunction

    // Plays picosoc and the slaves; ack_after = which cyc cycle the target acks (0 = never).
    task automatic run_txn(input logic [31:0] addr, input logic [3:0] wstrb,
                           input logic [31:0] wdata, input int ack_after,
                           input int target, input bit spur, output obs_t o);
        logic [NS-1:0] ack;
        o = '{default: 0};
        iomem_addr  = addr;
        iomem_wstrb = wstrb;
        iomem_wdata = wdata;
        iomem_valid = 1'b1;
        for (int c = 1; c <= MAXC; c++) begin
            @(posedge clk); #1;
            if (wbm_stb_o !== wbm_cyc_o) o.stb_bad++;
            if (wbm_cyc_o != '0) begin
                if (o.cyc_cycles == 0) begin
                    o.adr = wbm_adr_o; o.dat = wbm_dat_o;
                    o.sel = wbm_sel_o; o.we  = wbm_we_o;
                end
                o.cyc = o.cyc | wbm_cyc_o;
                o.cyc_cycles++;
            end
            if (bus_timeout === 1'b1) o.to_pulses++;
            ack = '0;
            for (int s = 0; s < NS; s++) begin
                if (s == target)
                    ack[s] = wbm_cyc_o[s] && (o.cyc_cycles == ack_after);
                else
                    ack[s] = spur ? 1'($urandom_range(0, 1)) : 1'b0;
            end
            wbm_ack_i = ack;
            if (iomem_ready === 1'b1) begin
                o.ready_cycle = c;
                o.rdata       = iomem_rdata;
                o.to_at_ready = bus_timeout;
                break;
            end
        end
        iomem_valid = 1'b0;
        wbm_ack_i   = '0;
        @(posedge clk); #1;
        o.ready_after = iomem_ready;
        o.cyc_after   = |wbm_cyc_o;
        o.to_after    = bus_timeout;
        o.err         = err_count;
    endtask

    task automatic compare(input string tag, input logic [31:0] addr, input logic [3:0] wstrb,
                           input logic [31:0] wdata, input exp_t e, input obs_t o);
        string p;
        txn_no++;
        p = $sformatf("%s#%0d", tag, txn_no);
        check({p, " ready_cycle"}, 32'(o.ready_cycle), 32'(e.ready));
        if (e.ready > 0) begin
            check({p, " rdata"}, o.rdata, e.rdata);
            check({p, " ready_width"}, 32'(o.ready_after), 32'd0);
            check({p, " timeout_at_ready"}, 32'(o.to_at_ready), 32'(e.to));
        end
        check({p, " timeout_pulses"}, 32'(o.to_pulses), 32'(e.to));
        check({p, " timeout_after"}, 32'(o.to_after), 32'd0);
        check({p, " cyc_onehot"}, 32'(o.cyc), 32'(e.cyc));
        check({p, " cyc_cycles"}, 32'(o.cyc_cycles), 32'(e.cycles));
        check({p, " stb_eq_cyc"}, 32'(o.stb_bad), 32'd0);
        check({p, " cyc_after"}, 32'(o.cyc_after), 32'd0);
        if (e.cyc != '0) begin
            check({p, " adr"}, o.adr, addr);
            check({p, " dat"}, o.dat, wdata);
            check({p, " sel"}, 32'(o.sel), 32'((wstrb != 4'h0) ? wstrb : 4'hF));
            check({p, " we"}, 32'(o.we), 32'(wstrb != 4'h0));
        end
        check({p, " err_count"}, 32'(o.err), 32'(e.err));
        $display("txn %0d %s addr=%h wstrb=%h ready@%0d rdata=%h cyc=%b err=%0d",
                 txn_no, tag, addr, wstrb, o.ready_cycle, o.rdata, o.cyc, o.err);
    endtask

    // Transaction-level model: what the CPU should see for this request.
    task automatic model_txn(input string tag, input logic [31:0] addr, input logic [3:0] wstrb,
                             input logic [31:0] wdata, input int ack_after, input bit spur);
        exp_t e;
        obs_t o;
        int   tgt;
        e   = '{default: 0};
        tgt = decode(addr);
        if (addr[31:24] < 8'h03) begin
            tgt = -1;
        end else if (tgt < 0) begin
            e.ready = 1; e.rdata = ERR;
            if (err_model != 8'hFF) err_model = err_model + 8'd1;
        end else begin
            e.cyc[tgt] = 1'b1;
            if (ack_after >= 1 && ack_after <= TO) begin
                e.ready = ack_after + 1; e.rdata = sdata[tgt]; e.cycles = ack_after;
            end else begin
                e.ready = TO + 1; e.rdata = ERR; e.to = 1'b1; e.cycles = TO;
                if (err_model != 8'hFF) err_model = err_model + 8'd1;
            end
        end
        e.err = err_model;
        run_txn(addr, wstrb, wdata, ack_after, tgt, spur, o);
        compare(tag, addr, wstrb, wdata, e, o);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " iomem_ready"}, 32'(iomem_ready), 32'd0);
        check({tag, " iomem_rdata"}, iomem_rdata, 32'd0);
        check({tag, " wbm_adr_o"}, wbm_adr_o, 32'd0);
        check({tag, " wbm_dat_o"}, wbm_dat_o, 32'd0);
        check({tag, " wbm_we_o"}, 32'(wbm_we_o), 32'd0);
        check({tag, " wbm_sel_o"}, 32'(wbm_sel_o), 32'd0);
        check({tag, " wbm_cyc_o"}, 32'(wbm_cyc_o), 32'd0);
        check({tag, " wbm_stb_o"}, 32'(wbm_stb_o), 32'd0);
        check({tag, " bus_timeout"}, 32'(bus_timeout), 32'd0);
        check({tag, " err_count"}, 32'(err_count), 32'd0);
    endtask

    vec_t vecs [11];

    initial begin
        obs_t          o;
        exp_t          e;
        logic [31:0]   addr;
        logic [3:0]    wstrb;

        base_a[0] = 32'h0300_0000; mask_a[0] = 32'hFFF0_0000;
        base_a[1] = 32'h0310_0000; mask_a[1] = 32'hFF00_0000;

        //          addr          wstrb  wdata          ack sp  rdy rdata          to cyc    cyc# err
        vecs[0]  = '{32'h0300_0000, 4'h3, 32'h0000_00A5, 2, 0, 3, 32'hFFFF_FFFF, 0, 2'b01, 2, 8'd0};
        vecs[1]  = '{32'h0310_0004, 4'h0, 32'h0000_0000, 3, 1, 4, 32'h1234_5678, 0, 2'b10, 3, 8'd0};
        vecs[2]  = '{32'h0310_0008, 4'h0, 32'h0000_0000, 0, 0, 5, ERR,           1, 2'b10, 4, 8'd1};
        vecs[3]  = '{32'h0400_0000, 4'h0, 32'h0000_0000, 1, 0, 1, ERR,           0, 2'b00, 0, 8'd2};
        vecs[4]  = '{32'h0200_0000, 4'h0, 32'h0000_0000, 1, 0, 0, 32'h0,         0, 2'b00, 0, 8'd2};
        vecs[5]  = '{32'h02FF_FFFC, 4'hF, 32'h5555_AAAA, 1, 1, 0, 32'h0,         0, 2'b00, 0, 8'd2};
        vecs[6]  = '{32'h0300_0010, 4'h0, 32'h0000_0000, 4, 0, 5, 32'hFFFF_FFFF, 0, 2'b01, 4, 8'd2};
        vecs[7]  = '{32'h0320_0000, 4'hF, 32'hDEAD_BEEF, 1, 1, 2, 32'h1234_5678, 0, 2'b10, 1, 8'd2};
        vecs[8]  = '{32'h0300_0004, 4'hC, 32'hCAFE_0000, 1, 1, 2, 32'hFFFF_FFFF, 0, 2'b01, 1, 8'd2};
        vecs[9]  = '{32'hFF00_0000, 4'h0, 32'h0000_0000, 1, 0, 1, ERR,           0, 2'b00, 0, 8'd3};
        vecs[10] = '{32'h0310_0000, 4'h0, 32'h0000_0000, 5, 0, 5, ERR,           1, 2'b10, 4, 8'd4};

        resetn      = 1'b0;
        iomem_valid = 1'b0;
        iomem_wstrb = 4'h0;
        iomem_addr  = 32'h0;
        iomem_wdata = 32'h0;
        wbm_ack_i   = '0;
        sdata[0]    = 32'hFFFF_FFFF;
        sdata[1]    = 32'h1234_5678;

        // Reset values, during and after a 3-cycle reset with valid low.
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("in_reset");
        resetn = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            check_all_zero("after_reset");
        end

        // Table-driven directed vectors.
        for (int i = 0; i < 11; i++) begin
            e.ready = vecs[i].ready; e.rdata = vecs[i].rdata; e.to = vecs[i].to;
            e.cyc = vecs[i].cyc; e.cycles = vecs[i].cycles; e.err = vecs[i].err;
            run_txn(vecs[i].addr, vecs[i].wstrb, vecs[i].wdata, vecs[i].ack_after,
                    (vecs[i].addr[31:24] < 8'h03) ? -1 : decode(vecs[i].addr),
                    vecs[i].spur, o);
            compare("vec", vecs[i].addr, vecs[i].wstrb, vecs[i].wdata, e, o);
        end
        err_model = vecs[10].err;

        // Randomized traffic against the model.
        for (int n = 0; n < 150; n++) begin
            sdata[0] = $urandom;
            sdata[1] = $urandom;
            case ($urandom_range(0, 3))
                0:       addr = {12'h030, 20'($urandom)};
                1:       addr = {8'h03, 24'($urandom)};
                2:       addr = {8'($urandom_range(4, 255)), 24'($urandom)};
                default: addr = {8'($urandom_range(0, 2)), 24'($urandom)};
            endcase
            wstrb = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
            model_txn("rand", addr, wstrb, $urandom, int'($urandom_range(0, 6)),
                      1'($urandom_range(0, 1)));
        end

        // Enough unmapped accesses to saturate the error counter.
        for (int n = 0; n < 300; n++) begin
            model_txn("unmapped", {8'($urandom_range(4, 255)), 24'($urandom)}, 4'h0, 32'h0, 1, 1'b0);
        end
        check("err_count_saturated", 32'(err_count), 32'h0000_00FF);

        // Reset in the middle of a bus cycle to slave 0.
        iomem_addr  = 32'h0300_0020;
        iomem_wstrb = 4'h0;
        iomem_valid = 1'b1;
        @(posedge clk); #1;
        iomem_valid = 1'b0;
        check("midrst cyc_before", 32'(wbm_cyc_o), 32'h1);
        @(posedge clk); #2;
        resetn = 1'b0;
        #1;
        check("midrst cyc", 32'(wbm_cyc_o), 32'h0);
        check("midrst stb", 32'(wbm_stb_o), 32'h0);
        check("midrst ready", 32'(iomem_ready), 32'h0);
        check("midrst err_count", 32'(err_count), 32'h0);
        check("midrst adr", wbm_adr_o, 32'h0);
        repeat (2) @(posedge clk);
        #3;
        resetn = 1'b1;
        @(posedge clk); #1;
        check_all_zero("post_midrst");
        err_model = 8'h0;
        sdata[1]  = 32'h0BAD_F00D;
        model_txn("fresh", 32'h0310_0010, 4'h0, 32'h0, 2, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/iomem_wb_bridge.md
# iomem_wb_bridge

Parametrised bridge from the picosoc iomem bus to a multi-slave Wishbone classic bus. It replaces the single-target bridge state machine in the board top level. It adds:
- per-slave address decode with one-hot strobes and a muxed read path;
- a bus-timeout watchdog;
- an immediate error response for unmapped addresses inside the bridge window.

It sits between `picosoc` iomem and peripherals such as the LED/button block and the multi-project harness.

## Interface
Parameters:
- NUM_SLAVES, 2: number of Wishbone slaves (1..8).
- WINDOW_MIN, 8'h03: iomem_addr[31:24] >= WINDOW_MIN is owned by the bridge.
- SLAVE_BASE, {32'h0310_0000, 32'h0300_0000}: flattened NUM_SLAVES×32 base addresses; slave i occupies bits [32*i+31:32*i].
- SLAVE_MASK, {32'hFFF0_0000, 32'hFFF0_0000}: flattened per-slave masks; slave i hits when (addr & mask_i) == (base_i & mask_i).
- TIMEOUT_CYCLES, 255: maximum strobe cycles without ack (1..65535).
- ERR_DATA, 32'hBADB_AD00: read data returned on timeout or unmapped access.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous active-low reset
- iomem_valid  in  1  picosoc request
- iomem_ready  out  1  one-cycle completion pulse
- iomem_wstrb  in  4  byte write strobes; 0 = read
- iomem_addr  in  32  byte address
- iomem_wdata  in  32  write data
- iomem_rdata  out  32  read data, valid while iomem_ready=1
- wbm_adr_o  out  32  shared address
- wbm_dat_o  out  32  shared write data
- wbm_we_o  out  1  write enable
- wbm_sel_o  out  4  byte selects; equals iomem_wstrb on writes, 4'hF on reads
- wbm_cyc_o  out  NUM_SLAVES  one-hot cycle
- wbm_stb_o  out  NUM_SLAVES  one-hot strobe, identical to wbm_cyc_o
- wbm_ack_i  in  NUM_SLAVES  per-slave ack
- wbm_dat_i  in  32*NUM_SLAVES  flattened per-slave read data
- bus_timeout  out  1  one-cycle pulse when a transaction times out
- err_count  out  8  saturating count of timeouts plus unmapped accesses

## Operation
- States are IDLE, BUS and DONE.
- **IDLE:** when iomem_valid=1 and iomem_addr[31:24] >= WINDOW_MIN, latch adr, dat, we (=|wstrb) and sel, then decode.
  - Decode is priority-based: the lowest matching index wins.
  - On a hit, assert the one-hot cyc/stb for that slave, clear the timeout counter and go to BUS.
  - On a miss (unmapped): issue no Wishbone cycle. Load iomem_rdata=ERR_DATA, pulse iomem_ready, increment err_count and go to DONE.
- Addresses below the window are ignored: no ready and no state change.
- **BUS:**
  - Only wbm_ack_i of the selected slave is honoured; acks from other slaves are ignored.
  - On ack: latch that slave's wbm_dat_i slice into iomem_rdata (writes also latch it; the value is don't-care), pulse iomem_ready, drop cyc/stb/we, go to DONE.
  - Otherwise increment the counter. When the counter reaches TIMEOUT_CYCLES-1 with no ack: drop cyc/stb/we, load ERR_DATA, pulse iomem_ready and bus_timeout, increment err_count, go to DONE.
  - If ack and the timeout coincide, ack wins and there is no error.
- **DONE:** iomem_ready=0, then go to IDLE unconditionally. This one-cycle gap guarantees picosoc has dropped iomem_valid before the next decode.
- err_count saturates at 8'hFF.
- Asynchronous reset forces, immediately, including mid-transaction:
  - state to IDLE;
  - all outputs to 0 (adr, dat, we, sel, cyc, stb, iomem_ready, iomem_rdata, bus_timeout, err_count);
  - the counter to 0.
  - The abandoned slave sees cyc fall with no further handshake.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- Cycle numbering for a mapped access:
  - cycle 0: valid is sampled in IDLE;
  - cycle 1: cyc/stb high;
  - cycle k: ack is sampled;
  - cycle k+1: iomem_ready high, cyc/stb low;
  - cycle k+2: back in IDLE.
- Minimum latency (combinational ack at cycle 1) is valid to ready in 2 cycles.
- Unmapped access: ready in cycle 1.
- Timeout: cyc/stb are high for exactly TIMEOUT_CYCLES cycles; ready and bus_timeout are then high in the next cycle.
- Back-to-back requests: a new request is earliest 1 cycle after DONE.

## Test plan
- **Reset values:** hold resetn=0 for 3 cycles, then release. All outputs read 0; no cyc is asserted while valid=0.
- **Write to slave 0:** addr 32'h0300_0000, wstrb 4'h3, wdata 32'h0000_00A5; slave 0 acks at cycle 2.
  - Required: wbm_cyc_o=2'b01, sel=4'h3, we=1, dat_o=32'h0000_00A5.
  - Required: iomem_ready at cycle 3 for exactly 1 cycle.
- **Read from slave 1:** addr 32'h0310_0004, wstrb 0. Slave 1 drives 32'h1234_5678 while slave 0 drives 32'hFFFF_FFFF and a spurious ack.
  - Required: cyc=2'b10, sel=4'hF, iomem_rdata=32'h1234_5678.
  - Required: the slave-0 ack is ignored.
- **Timeout:** TIMEOUT_CYCLES=4; slave 1 never acks.
  - Required: cyc high for 4 cycles, then iomem_ready=1, iomem_rdata=32'hBADB_AD00, bus_timeout=1 for one cycle, err_count=1.
- **Unmapped and out-of-window:**
  - addr 32'h0400_0000: ready at cycle 1, rdata=ERR_DATA, no cyc, err_count increments.
  - addr 32'h0200_0000: no ready, no cyc.
  - 300 unmapped accesses leave err_count=8'hFF.
- **Reset mid-transaction:** assert resetn=0 during BUS with cyc=2'b01.
  - Required: cyc, stb and ready go to 0 immediately.
  - Required: after release, a fresh read completes normally.
